// File: rtl/syn_data_mem_banked_if.sv
// Request/response and debug bus of the banked data memory.
// Op codes: 0=WD, 1=UH, 2=SH, 3=UB, 4=SB.
interface syn_data_mem_banked_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic        w_en;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        rsp_valid;
    logic [31:0] data;
    logic        misalign;
    logic [31:0] addr_dbg;
    logic [31:0] data_dbg;

    modport master (
        output req_valid, op, w_en, addr, data_in, addr_dbg,
        input  req_ready, rsp_valid, data, misalign, data_dbg
    );

    modport slave (
        input  req_valid, op, w_en, addr, data_in, addr_dbg,
        output req_ready, rsp_valid, data, misalign, data_dbg
    );
endinterface

// File: rtl/syn_data_mem_banked.sv
// Word-organised data memory with sub-word loads/stores, RD_LAT-cycle read pipeline,
// misalignment flag, registered debug read port and optional post-reset clear sweep.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zero one word per enabled cycle, requests refused
// ST_RUN   | normal operation, req_ready follows en
module syn_data_mem_banked #(
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1,
    parameter int CLEAR_INIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    syn_data_mem_banked_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] DM_OP_WD = 3'd0;
    localparam logic [2:0] DM_OP_UH = 3'd1;
    localparam logic [2:0] DM_OP_SH = 3'd2;
    localparam logic [2:0] DM_OP_UB = 3'd3;
    localparam logic [2:0] DM_OP_SB = 3'd4;

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_lat_chk
            $error("syn_data_mem_banked: RD_LAT must be 1 or 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [31:0]         mem_q [DEPTH];

    logic                req_ready;
    logic                clr_we;
    logic                accept;
    logic                acc_load;
    logic                mis;
    logic [ADDR_W-1:0]   word_idx;
    logic [ADDR_W-1:0]   dbg_idx;
    logic [1:0]          lane;
    logic [31:0]         rd_word;
    logic [31:0]         ld_val;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_idx;
    logic [31:0]         wr_data;
    logic [3:0]          wr_be;

    logic [RD_LAT-1:0]   pv_q, pv_d;
    logic [31:0]         pd_q [RD_LAT];
    logic [31:0]         pd_d [RD_LAT];
    logic                misalign_q, misalign_d;
    logic [31:0]         data_dbg_q, data_dbg_d;

    logic                unused_addr_bits;

    function automatic logic [31:0] extend_load(input logic [2:0]  op_i,
                                                input logic [1:0]  lane_i,
                                                input logic [31:0] word_i);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word_i >> {lane_i, 3'b000});
        h = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (op_i)
            DM_OP_UH: extend_load = {16'h0000, h};
            DM_OP_SH: extend_load = {{16{h[15]}}, h};
            DM_OP_UB: extend_load = {24'h000000, b};
            DM_OP_SB: extend_load = {{24{b[7]}}, b};
            default:  extend_load = word_i;
        endcase
    endfunction

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= (CLEAR_INIT != 0) ? ST_CLEAR : ST_RUN;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (en) begin
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    if (&clr_ptr_q) state_d = ST_RUN;
                end
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // FSM: outputs; rst_n gates ready so it is 0 during reset even without a sweep
    always_comb begin
        req_ready = 1'b0;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: clr_we    = en;
            ST_RUN:   req_ready = en & rst_n;
            default:  req_ready = 1'b0;
        endcase
    end

    assign word_idx = bus.addr[ADDR_W+1:2];
    assign dbg_idx  = bus.addr_dbg[ADDR_W+1:2];
    assign lane     = bus.addr[1:0];
    assign accept   = bus.req_valid & req_ready;
    assign acc_load = accept & ~bus.w_en;

    assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr_dbg[31:ADDR_W+2],
                                bus.addr_dbg[1:0]};

    always_comb begin
        case (bus.op)
            DM_OP_UH, DM_OP_SH: mis = bus.addr[0];
            DM_OP_UB, DM_OP_SB: mis = 1'b0;
            default:            mis = |bus.addr[1:0];
        endcase
    end

    // Loads sample the array before the accepting edge, so a later store cannot leak in.
    assign rd_word = mem_q[word_idx];
    assign ld_val  = mis ? 32'h0 : extend_load(bus.op, lane, rd_word);

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = word_idx;
        wr_data = bus.data_in;
        wr_be   = 4'b0000;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_idx  = clr_ptr_q;
            wr_data = 32'h0;
            wr_be   = 4'b1111;
        end else if (accept && bus.w_en && !mis) begin
            wr_en = 1'b1;
            case (bus.op)
                DM_OP_UB, DM_OP_SB: begin
                    wr_data = {4{bus.data_in[7:0]}};
                    wr_be   = 4'b0001 << lane;
                end
                DM_OP_UH, DM_OP_SH: begin
                    wr_data = {2{bus.data_in[15:0]}};
                    wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                end
                default: wr_be = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Each stage only takes new data when a valid load moves into it, so the
    // output stage holds the last load result between responses.
    always_comb begin
        pv_d       = pv_q;
        misalign_d = misalign_q;
        for (int i = 0; i < RD_LAT; i++) pd_d[i] = pd_q[i];
        if (en) begin
            misalign_d = accept & mis;
            pv_d[0]    = acc_load;
            if (acc_load) pd_d[0] = ld_val;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_d[i] = pv_q[i-1];
                if (pv_q[i-1]) pd_d[i] = pd_q[i-1];
            end
        end
    end

    assign data_dbg_d = mem_q[dbg_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q       <= '0;
            pd_q       <= '{default: 32'h0};
            misalign_q <= 1'b0;
            data_dbg_q <= 32'h0;
        end else begin
            pv_q       <= pv_d;
            pd_q       <= pd_d;
            misalign_q <= misalign_d;
            data_dbg_q <= data_dbg_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = pv_q[RD_LAT-1];
    assign bus.data      = pd_q[RD_LAT-1];
    assign bus.misalign  = misalign_q;
    assign bus.data_dbg  = data_dbg_q;

endmodule

// File: tb/tb_syn_data_mem_banked.sv
// Bench for syn_data_mem_banked: byte-array reference model with an in-flight load
// queue, checked every cycle, plus directed scenarios pinned by literal values.
module tb_syn_data_mem_banked;

    localparam int AW  = 4;
    localparam int LAT = 2;
    localparam int NW  = 16;

    localparam logic [2:0] OP_WD = 3'd0;
    localparam logic [2:0] OP_UH = 3'd1;
    localparam logic [2:0] OP_SH = 3'd2;
    localparam logic [2:0] OP_UB = 3'd3;
    localparam logic [2:0] OP_SB = 3'd4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b0;

    syn_data_mem_banked_if bus ();

    syn_data_mem_banked #(.ADDR_W(AW), .RD_LAT(LAT), .CLEAR_INIT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          rem;
        logic [31:0] val;
    } pend_t;

    byte unsigned mm [NW*4];
    bit           known [NW];
    int           clr_left = NW;
    pend_t        pq [$];
    logic [31:0]  e_data = 32'h0;
    logic [31:0]  e_dbg  = 32'h0;
    bit           e_dbg_known = 1'b1;
    bit           e_rsp = 1'b0;
    bit           e_mis = 1'b0;

    function automatic logic [31:0] mword(input int w);
        return {mm[w*4+3], mm[w*4+2], mm[w*4+1], mm[w*4]};
    endfunction

    function automatic bit m_mis(input logic [2:0] op, input logic [31:0] a);
        if (op == OP_WD) return (a % 4) != 0;
        if (op == OP_UH || op == OP_SH) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a);
        int w = int'((a / 4) % NW);
        int p = w * 4 + int'(a % 4);
        case (op)
            OP_UB:   return 32'(mm[p]);
            OP_SB:   return 32'(int'(byte'(mm[p])));
            OP_UH:   return 32'(mm[p]) | (32'(mm[p+1]) << 8);
            OP_SH:   return 32'(int'(shortint'({mm[p+1], mm[p]})));
            default: return mword(w);
        endcase
    endfunction

    function automatic void m_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int w = int'((a / 4) % NW);
        int p = w * 4 + int'(a % 4);
        case (op)
            OP_UB, OP_SB: mm[p] = d[7:0];
            OP_UH, OP_SH: begin
                mm[p]   = d[7:0];
                mm[p+1] = d[15:8];
            end
            default: for (int i = 0; i < 4; i++) mm[w*4+i] = d[8*i +: 8];
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            clr_left    = NW;
            pq.delete();
            e_data      = 32'h0;
            e_dbg       = 32'h0;
            e_dbg_known = 1'b1;
            e_rsp       = 1'b0;
            e_mis       = 1'b0;
        end else begin : step
            int          dw;
            logic [31:0] dv;
            bit          dk, acc, mis;
            dw = int'((bus.addr_dbg / 4) % NW);
            dk = known[dw];
            dv = mword(dw);
            if (en) begin
                acc = bus.req_valid && (clr_left == 0);
                mis = m_mis(bus.op, bus.addr);
                if (clr_left > 0) begin
                    for (int i = 0; i < 4; i++) mm[(NW-clr_left)*4+i] = 8'h00;
                    known[NW-clr_left] = 1'b1;
                    clr_left--;
                end
                foreach (pq[i]) pq[i].rem--;
                if (acc && !bus.w_en)
                    pq.push_back('{rem: LAT-1, val: (mis ? 32'h0 : m_load(bus.op, bus.addr))});
                if (acc && bus.w_en && !mis) m_store(bus.op, bus.addr, bus.data_in);
                e_mis = acc && mis;
                if (pq.size() > 0 && pq[0].rem == 0) begin
                    e_rsp  = 1'b1;
                    e_data = pq[0].val;
                    void'(pq.pop_front());
                end else begin
                    e_rsp = 1'b0;
                end
            end
            e_dbg       = dv;
            e_dbg_known = dk;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'(en && clr_left == 0 && rst_n));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
        check("data", bus.data, e_data);
        check("misalign", 32'(bus.misalign), 32'(e_mis));
        if (e_dbg_known) check("data_dbg", bus.data_dbg, e_dbg);
    end

    // ---------------- response collector ----------------
    int          cyc = 0;
    bit          en_prev = 1'b0;
    logic [31:0] got_q [$];
    int          got_c [$];

    initial forever begin
        @(posedge clk);
        cyc++;
        en_prev = en;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && en_prev && bus.rsp_valid) begin
            got_q.push_back(bus.data);
            got_c.push_back(cyc);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_req(input logic [2:0] op, input bit we, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.op        = op;
        bus.w_en      = we;
        bus.addr      = a;
        bus.data_in   = d;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_got(input string name, input logic [31:0] exp, output int c);
        c = -1;
        for (int i = 0; i < 20 && got_q.size() == 0; i++) tick();
        if (got_q.size() == 0) begin
            check({name, "_timeout"}, 32'(got_q.size()), 32'd1);
        end else begin
            c = got_c.pop_front();
            check(name, got_q.pop_front(), exp);
        end
    endtask

    task automatic count_clear(input string name);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
        end
        check(name, 32'(n), 32'd16);
        tick();
    endtask

    task automatic check_async_zero(input string tag);
        check({tag, "_data"},      bus.data,                32'h0);
        check({tag, "_data_dbg"},  bus.data_dbg,            32'h0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid),      32'h0);
        check({tag, "_misalign"},  32'(bus.misalign),       32'h0);
        check({tag, "_req_ready"}, 32'(bus.req_ready),      32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0, c1, c2, a0, cx;
        bus.req_valid = 1'b0;
        bus.op        = OP_WD;
        bus.w_en      = 1'b0;
        bus.addr      = 32'h0;
        bus.data_in   = 32'h0;
        bus.addr_dbg  = 32'h0;
        #1;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) tick();
        check_async_zero("reset");

        // post-reset clear sweep, then every word reads 0 on the debug port (aliased address)
        rst_n = 1'b1;
        count_clear("clear_len");
        for (int w = 0; w < NW; w++) begin
            bus.addr_dbg = 32'(w * 4) + 32'h40;
            tick();
            check("dbg_cleared", bus.data_dbg, 32'h0);
        end

        // sub-word loads after a word store
        got_q.delete(); got_c.delete();
        do_req(OP_WD, 1'b1, 32'h8, 32'hDEADBEEF);
        do_req(OP_SB, 1'b0, 32'h9, 32'h0);
        do_req(OP_UB, 1'b0, 32'h9, 32'h0);
        expect_got("sb_0x9", 32'hFFFFFFBE, cx);
        expect_got("ub_0x9", 32'h000000BE, cx);

        // half store merge, misaligned load/store
        do_req(OP_SH, 1'b1, 32'hA, 32'hFFFF1234);
        do_req(OP_WD, 1'b0, 32'h8, 32'h0);
        expect_got("wd_after_sh", 32'h1234BEEF, cx);
        do_req(OP_SH, 1'b0, 32'hB, 32'h0);
        check("mis_load_pulse", 32'(bus.misalign), 32'd1);
        expect_got("mis_load_zero", 32'h0, cx);
        do_req(OP_WD, 1'b1, 32'h6, 32'hFFFFFFFF);
        check("mis_store_pulse", 32'(bus.misalign), 32'd1);
        tick();
        check("mis_one_cycle", 32'(bus.misalign), 32'd0);
        do_req(OP_WD, 1'b0, 32'h4, 32'h0);
        expect_got("word1_unchanged", 32'h0, cx);

        // back-to-back loads, latency and ordering
        do_req(OP_WD, 1'b1, 32'h0, 32'h11223344);
        do_req(OP_WD, 1'b1, 32'h4, 32'h55667788);
        a0 = cyc;
        do_req(OP_WD, 1'b0, 32'h0, 32'h0);
        do_req(OP_WD, 1'b0, 32'h4, 32'h0);
        do_req(OP_WD, 1'b0, 32'h8, 32'h0);
        expect_got("b2b_0", 32'h11223344, c0);
        expect_got("b2b_1", 32'h55667788, c1);
        expect_got("b2b_2", 32'h1234BEEF, c2);
        check("lat_first", 32'(c0 - a0), 32'd2);
        check("lat_gap1", 32'(c1 - c0), 32'd1);
        check("lat_gap2", 32'(c2 - c1), 32'd1);

        // en=0 for 3 cycles with one load in each pipeline stage; a store is offered meanwhile
        got_q.delete(); got_c.delete();
        do_req(OP_WD, 1'b0, 32'h8, 32'h0);
        do_req(OP_WD, 1'b0, 32'h0, 32'h0);
        en            = 1'b0;
        bus.req_valid = 1'b1;
        bus.op        = OP_WD;
        bus.w_en      = 1'b1;
        bus.addr      = 32'h0;
        bus.data_in   = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frozen_valid", 32'(bus.rsp_valid), 32'd1);
            check("frozen_data", bus.data, 32'h1234BEEF);
        end
        bus.req_valid = 1'b0;
        en            = 1'b1;
        expect_got("freeze_first", 32'h1234BEEF, cx);
        expect_got("freeze_second", 32'h11223344, cx);
        repeat (4) tick();
        check("no_dup_rsp", 32'(got_q.size()), 32'd0);
        do_req(OP_WD, 1'b0, 32'h0, 32'h0);
        expect_got("store_ignored", 32'h11223344, cx);

        // randomized traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [2:0]  op;
            op = 3'($urandom_range(0, 4));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                a[1:0] = 2'b00;
                if (op == OP_UB || op == OP_SB) a[1:0] = 2'($urandom_range(0, 3));
                else if (op == OP_UH || op == OP_SH) a[1] = 1'($urandom_range(0, 1));
            end
            en            = ($urandom_range(0, 9) != 0);
            bus.req_valid = ($urandom_range(0, 9) < 7);
            bus.op        = op;
            bus.w_en      = 1'($urandom_range(0, 1));
            bus.addr      = a;
            bus.data_in   = $urandom;
            bus.addr_dbg  = $urandom;
            tick();
        end
        bus.req_valid = 1'b0;
        en            = 1'b1;
        repeat (4) tick();
        got_q.delete(); got_c.delete();

        // reset pulse in the middle of the clear sweep
        do_req(OP_WD, 1'b1, 32'h28, 32'hCAFEF00D);
        do_req(OP_WD, 1'b0, 32'h28, 32'h0);
        expect_got("pre_reset_load", 32'hCAFEF00D, cx);
        bus.addr_dbg = 32'h28;
        tick();
        rst_n = 1'b0;
        #1;
        check_async_zero("async_rst1");
        tick();
        rst_n = 1'b1;
        repeat (7) tick();
        check("dbg_mid_sweep", bus.data_dbg, 32'hCAFEF00D);
        rst_n = 1'b0;
        #1;
        check_async_zero("async_rst2");
        tick();
        rst_n = 1'b1;
        count_clear("clear_restart");
        tick();
        check("dbg_word10_cleared", bus.data_dbg, 32'h0);
        got_q.delete(); got_c.delete();
        do_req(OP_WD, 1'b0, 32'h28, 32'h0);
        expect_got("load_word10_cleared", 32'h0, cx);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
